// File: rtl/cpu_types_pkg.sv
// Shared CPU types: datapath word, ALU opcodes and the request-unit state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef enum logic [1:0] {
        RQ_IDLE  = 2'b00,
        RQ_FETCH = 2'b01,
        RQ_DATA  = 2'b10,
        RQ_HALT  = 2'b11
    } reqstate_t;

endpackage

// File: rtl/request_unit_if.sv
// Bundle of the request unit's control-side, memory-side and PC-side signals.
interface request_unit_if (input logic CLK);
    logic RST;
    logic iREN;
    logic dREN;
    logic dWEN;
    logic halt;
    logic ihit;
    logic dhit;
    logic imemREN;
    logic dmemREN;
    logic dmemWEN;
    logic pcEN;
    logic halted;
    logic err;

    modport req (
        input  CLK, RST, iREN, dREN, dWEN, halt, ihit, dhit,
        output imemREN, dmemREN, dmemWEN, pcEN, halted, err
    );

    modport tb (
        input  CLK, imemREN, dmemREN, dmemWEN, pcEN, halted, err,
        output RST, iREN, dREN, dWEN, halt, ihit, dhit
    );
endinterface

// File: rtl/req_wait_counter.sv
// Saturating wait counter; at_max flags that the current wait has reached WAIT_MAX cycles.
module req_wait_counter #(
    parameter int CNT_W    = 8,
    parameter int WAIT_MAX = 255
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    localparam logic [CNT_W-1:0] CNT_ALL_ONES = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LIMIT    = CNT_W'(WAIT_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;

    // Clear wins over increment; the count sticks at all-ones instead of wrapping.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (clr) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (inc && (r_cnt != CNT_ALL_ONES)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign at_max = (r_cnt >= CNT_LIMIT);

endmodule

// File: rtl/request_unit.sv
// Converts control-unit request levels into imem/dmem handshakes, pulses pcEN per
// retired instruction, parks on halt and keeps a sticky protocol/timeout error.
module request_unit
    import cpu_types_pkg::*;
#(
    parameter int WAIT_MAX = 255,
    parameter int CNT_W    = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic iREN,
    input  logic dREN,
    input  logic dWEN,
    input  logic halt,
    input  logic ihit,
    input  logic dhit,
    output logic imemREN,
    output logic dmemREN,
    output logic dmemWEN,
    output logic pcEN,
    output logic halted,
    output logic err
);

    reqstate_t r_state;
    reqstate_t w_state_next;
    logic      r_rd_q;
    logic      r_wr_q;
    logic      r_err;
    logic      w_rd_next;
    logic      w_wr_next;
    logic      w_pcen;
    logic      w_inc;
    logic      w_clr;
    logic      w_err_set;
    logic      w_at_max;

    // Next-state, data-latch, retire-pulse and wait-increment decode.
    always_comb begin
        w_state_next = r_state;
        w_rd_next    = r_rd_q;
        w_wr_next    = r_wr_q;
        w_pcen       = 1'b0;
        w_inc        = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            RQ_IDLE: begin
                w_state_next = RQ_FETCH;
            end
            RQ_FETCH: begin
                if (ihit) begin
                    if (halt) begin
                        w_state_next = RQ_HALT;
                    end else if (dREN || dWEN) begin
                        // A simultaneous read and write is malformed: the write wins.
                        w_rd_next    = dREN & ~dWEN;
                        w_wr_next    = dWEN;
                        w_err_set    = dREN & dWEN;
                        w_state_next = RQ_DATA;
                    end else begin
                        w_pcen = 1'b1;
                    end
                end else begin
                    w_inc = iREN;
                end
            end
            RQ_DATA: begin
                if (dhit) begin
                    w_pcen       = 1'b1;
                    w_rd_next    = 1'b0;
                    w_wr_next    = 1'b0;
                    w_state_next = RQ_FETCH;
                end else begin
                    w_inc = 1'b1;
                end
            end
            RQ_HALT: begin
                w_state_next = RQ_HALT;
            end
            default: begin
                w_state_next = RQ_IDLE;
            end
        endcase
    end

    // A retire in RQ_FETCH starts a fresh fetch wait even though the state is unchanged.
    assign w_clr = (w_state_next != r_state) | w_pcen;

    req_wait_counter #(
        .CNT_W    (CNT_W),
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_counter (
        .CLK    (CLK),
        .RST    (RST),
        .clr    (w_clr),
        .inc    (w_inc),
        .at_max (w_at_max)
    );

    // State, request latches and sticky error.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= RQ_IDLE;
            r_rd_q  <= 1'b0;
            r_wr_q  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_rd_q  <= w_rd_next;
            r_wr_q  <= w_wr_next;
            r_err   <= r_err | w_err_set | w_at_max;
        end
    end

    // imemREN forwards the fetch request level while fetching; the rest decode from registers.
    assign imemREN = (r_state == RQ_FETCH) & iREN;
    assign dmemREN = (r_state == RQ_DATA) & r_rd_q;
    assign dmemWEN = (r_state == RQ_DATA) & r_wr_q;
    assign pcEN    = w_pcen;
    assign halted  = (r_state == RQ_HALT);
    assign err     = r_err | w_at_max;

endmodule
